// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU and its two-requester arbiter: ALU operation codes,
// arbiter FSM state encoding and the registered response bundle.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_XOR = 4'b1000,
        ALU_NOR = 4'b1100
    } alu_control_t;

    // Plain vector plus constants keeps the state encoding legacy-compatible.
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t S_IDLE = 1'b0;
    localparam arb_state_t S_BUSY = 1'b1;

    typedef struct packed {
        logic [31:0] result;
        logic        overflow;
        logic        zero;
        logic        equal;
    } alu_resp_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: logic ops, add/sub with signed overflow, set-less-than,
// plus zero and operand-equality flags.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_control_t control,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);

    logic [N-1:0] sum_s;
    logic [N-1:0] diff_s;

    assign sum_s  = a + b;
    assign diff_s = a - b;

    // Operation select; overflow is only meaningful for ADD and SUB.
    always_comb begin
        result   = {N{1'b0}};
        overflow = 1'b0;
        case (control)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD: begin
                result   = sum_s;
                overflow = (a[N-1] == b[N-1]) && (sum_s[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                result   = diff_s;
                overflow = (a[N-1] != b[N-1]) && (diff_s[N-1] != a[N-1]);
            end
            ALU_SLT: result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                result   = {N{1'b0}};
                overflow = 1'b0;
            end
        endcase
    end

    assign zero  = (result == {N{1'b0}});
    assign equal = (a == b);

endmodule

// File: rtl/rr_grant2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the requester
// that did not win last time. Output is one-hot, or zero when nobody asks.
module rr_grant2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Tie-break against the previous winner.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration; the
// result and flags are registered and held until the owning requester takes them.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  alu_control_t control0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  alu_control_t control1,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [N-1:0] resp_result,
    output logic         resp_overflow,
    output logic         resp_zero,
    output logic         resp_equal
);

    arb_state_t   state_r;
    logic         owner_r;
    logic         last_grant_r;
    logic [1:0]   resp_valid_r;
    logic [N-1:0] resp_result_r;
    logic         resp_overflow_r;
    logic         resp_zero_r;
    logic         resp_equal_r;

    logic [1:0]   grant_s;
    logic         sel_s;
    logic         accept_s;
    logic [N-1:0] alu_a_s;
    logic [N-1:0] alu_b_s;
    alu_control_t alu_control_s;
    logic [N-1:0] alu_result_s;
    logic         alu_overflow_s;
    logic         alu_zero_s;
    logic         alu_equal_s;

    rr_grant2 u_rr_grant2 (
        .valid      (req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // With no grant sel_s is 0, so requester 0 drives the ALU by default.
    assign sel_s = grant_s[1];

    // Operand mux into the shared ALU.
    always_comb begin
        if (sel_s) begin
            alu_a_s       = a1;
            alu_b_s       = b1;
            alu_control_s = control1;
        end else begin
            alu_a_s       = a0;
            alu_b_s       = b0;
            alu_control_s = control0;
        end
    end

    alu #(.N(N)) u_alu (
        .a        (alu_a_s),
        .b        (alu_b_s),
        .control  (alu_control_s),
        .result   (alu_result_s),
        .overflow (alu_overflow_s),
        .zero     (alu_zero_s),
        .equal    (alu_equal_s)
    );

    // Ready depends only on state and req_valid, never on resp_ready.
    always_comb begin
        if (rst_n && (state_r == S_IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
    end

    assign accept_s = |(req_valid & req_ready);

    // Arbitration FSM and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            owner_r         <= 1'b0;
            last_grant_r    <= 1'b1;
            resp_valid_r    <= 2'b00;
            resp_result_r   <= {N{1'b0}};
            resp_overflow_r <= 1'b0;
            resp_zero_r     <= 1'b0;
            resp_equal_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_r         <= S_BUSY;
                        owner_r         <= sel_s;
                        last_grant_r    <= sel_s;
                        resp_valid_r    <= sel_s ? 2'b10 : 2'b01;
                        resp_result_r   <= alu_result_s;
                        resp_overflow_r <= alu_overflow_s;
                        resp_zero_r     <= alu_zero_s;
                        resp_equal_r    <= alu_equal_s;
                    end
                end
                S_BUSY: begin
                    if (resp_ready[owner_r]) begin
                        state_r      <= S_IDLE;
                        resp_valid_r <= 2'b00;
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    resp_valid_r <= 2'b00;
                end
            endcase
        end
    end

    assign resp_valid    = resp_valid_r;
    assign resp_result   = resp_result_r;
    assign resp_overflow = resp_overflow_r;
    assign resp_zero     = resp_zero_r;
    assign resp_equal    = resp_equal_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a transaction-level arbiter/ALU model pushes
// expected responses; a negedge monitor checks handshakes and pops responses.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [31:0]  a0, b0, a1, b1;
    alu_control_t control0, control1;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [31:0]  resp_result;
    logic         resp_overflow, resp_zero, resp_equal;

    alu_arbiter #(.N(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .a0            (a0),
        .b0            (b0),
        .control0      (control0),
        .a1            (a1),
        .b1            (b1),
        .control1      (control1),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_overflow (resp_overflow),
        .resp_zero     (resp_zero),
        .resp_equal    (resp_equal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        o;
        logic        z;
        logic        e;
        int          who;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    int   grant_log[$];
    int   acc_cnt[2] = '{0, 0};
    bit   mdl_busy = 1'b0;
    int   mdl_owner = 0;
    int   mdl_last = 1;
    int   rst_cycles = 0;

    alu_control_t ctl_list[7] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR, ALU_NOR};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference ALU in plain signed arithmetic.
    function automatic exp_t alu_behavioural(input logic [31:0] a, input logic [31:0] b,
                                             input alu_control_t c, input int who);
        exp_t   x;
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        x.o = 1'b0;
        x.who = who;
        case (c)
            ALU_AND: x.r = a & b;
            ALU_OR:  x.r = a | b;
            ALU_XOR: x.r = a ^ b;
            ALU_NOR: x.r = ~(a | b);
            ALU_ADD: begin
                s = sa + sb;
                x.r = s[31:0];
                x.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SUB: begin
                s = sa - sb;
                x.r = s[31:0];
                x.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SLT: x.r = (sa < sb) ? 32'd1 : 32'd0;
            default: x.r = 32'd0;
        endcase
        x.z = (x.r == 32'd0);
        x.e = (a == b);
        return x;
    endfunction

    // Monitor: predicts ready/valid from the arbitration rules and scores responses.
    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        exp_t       e;
        int         g;
        if (!rst_n) begin
            check("rdy_in_reset", {30'd0, req_ready}, 32'd0);
            if (rst_cycles > 0) begin
                check("vld_in_reset", {30'd0, resp_valid}, 32'd0);
                check("res_in_reset", resp_result, 32'd0);
            end
            rst_cycles++;
            mdl_busy = 1'b0;
            mdl_last = 1;
            sb_q.delete();
        end else begin
            rst_cycles = 0;
            if (mdl_busy) exp_rdy = 2'b00;
            else if (req_valid == 2'b11) exp_rdy = (mdl_last == 1) ? 2'b01 : 2'b10;
            else exp_rdy = req_valid;
            check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
            check("resp_valid", {30'd0, resp_valid},
                  mdl_busy ? (32'd1 << mdl_owner) : 32'd0);
            if (mdl_busy) begin
                check("sb_nonempty", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q[0];
                    check("resp_result", resp_result, e.r);
                    check("resp_flags", {29'd0, resp_overflow, resp_zero, resp_equal},
                          {29'd0, e.o, e.z, e.e});
                    if (resp_ready[mdl_owner]) begin
                        void'(sb_q.pop_front());
                        mdl_busy = 1'b0;
                    end
                end
            end else if ((req_valid & exp_rdy) != 2'b00) begin
                g = exp_rdy[1] ? 1 : 0;
                if (g == 1) e = alu_behavioural(a1, b1, control1, 1);
                else        e = alu_behavioural(a0, b0, control0, 0);
                sb_q.push_back(e);
                mdl_busy  = 1'b1;
                mdl_owner = g;
                mdl_last  = g;
                grant_log.push_back(g);
                acc_cnt[g]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_ops();
        a0 = $urandom();
        b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom();
        a1 = $urandom();
        b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom();
        control0 = ctl_list[$urandom_range(0, 6)];
        control1 = ctl_list[$urandom_range(0, 6)];
    endtask

    task automatic drain();
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        repeat (3) tick();
        resp_ready = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 2'b00;
        rand_ops();

        // Reset with both requesters valid, then first tie must go to requester 0.
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_tie", {30'd0, req_ready}, 32'd1);
        tick();
        drain();

        // Lone requester 1: signed overflow on ADD.
        req_valid = 2'b10;
        a1 = 32'h7FFF_FFFF; b1 = 32'h0000_0001; control1 = ALU_ADD;
        @(negedge clk);
        check("single_ready", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("single_valid", {30'd0, resp_valid}, 32'd2);
        check("single_result", resp_result, 32'h8000_0000);
        check("single_flags", {29'd0, resp_overflow, resp_zero, resp_equal}, 32'b100);
        tick();
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;

        // Requester 0: SUB of equal operands gives zero and equal.
        req_valid = 2'b01;
        a0 = 32'h1234_5678; b0 = 32'h1234_5678; control0 = ALU_SUB;
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        check("sub_result", resp_result, 32'd0);
        check("sub_flags", {29'd0, resp_overflow, resp_zero, resp_equal}, 32'b011);
        tick();
        drain();

        // Contention: grants must strictly alternate.
        base = grant_log.size();
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        n = 0;
        while (grant_log.size() < base + 8 && n < 40) begin
            rand_ops();
            tick();
            n++;
        end
        req_valid = 2'b00;
        check("contention_count", (grant_log.size() >= base + 8) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 1; i < 8; i++) begin
            if (base + i < grant_log.size())
                check("alternate", grant_log[base + i], 32'(1 - grant_log[base + i - 1]));
        end
        drain();

        // Backpressure: response held 5 cycles, no new accepts.
        req_valid = 2'b01;
        resp_ready = 2'b00;
        a0 = 32'hFFFF_0000; b0 = 32'h0F0F_0F0F; control0 = ALU_OR;
        tick();
        req_valid = 2'b11;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", {30'd0, resp_valid}, 32'd1);
            check("bp_ready", {30'd0, req_ready}, 32'd0);
            check("bp_result", resp_result, 32'hFFFF_0F0F);
        end
        tick();
        resp_ready = 2'b01;
        req_valid  = 2'b00;
        tick();
        resp_ready = 2'b00;
        @(negedge clk);
        check("bp_idle", {30'd0, resp_valid}, 32'd0);

        // Reset while busy on requester 0: pending response dropped, next tie goes to 0.
        tick();
        req_valid = 2'b01;
        rand_ops();
        tick();
        req_valid = 2'b11;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", {30'd0, resp_valid}, 32'd0);
        check("rst_mid_tie", {30'd0, req_ready}, 32'd1);
        tick();
        drain();

        // Random traffic until each requester has 25 more accepted operations.
        base = (acc_cnt[0] < acc_cnt[1]) ? acc_cnt[1] : acc_cnt[0];
        n = 0;
        while ((acc_cnt[0] < base + 25 || acc_cnt[1] < base + 25) && n < 3000) begin
            rand_ops();
            req_valid  = 2'(($urandom_range(0, 3)));
            resp_ready = 2'(($urandom_range(0, 3)));
            tick();
            n++;
        end
        check("random_done", (n < 3000) ? 32'd1 : 32'd0, 32'd1);
        drain();
        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
